player_vertical_motion: RTL and testbench

- Consumer side of the gravity-direction interface. Takes `dir` and the `lines` presence vector, integrates vertical motion once per frame tick, and drives `height` and `is_dead`. The gravity-direction block reads both of those back.
- Sits between the frame-tick generator and the renderer/collision logic. It closes the loop with the gravity-switch logic.

---
 rtl/player_vertical_motion_if.sv | 13 +
 rtl/player_vertical_motion.sv | 163 ++++++++++++++++
 tb/tb_player_vertical_motion.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/player_vertical_motion_if.sv
// Gravity-direction <-> vertical-motion link: tick/dir/lines forward, height and status back.
interface player_vertical_motion_if;
    logic       tick;
    logic       dir;
    logic [2:0] lines;
    logic [8:0] height;
    logic       grounded;
    logic       landed;
    logic       is_dead;

    modport master (output tick, dir, lines, input height, grounded, landed, is_dead);
    modport slave  (input tick, dir, lines, output height, grounded, landed, is_dead);
endinterface

// File: rtl/player_vertical_motion.sv
// Per-frame vertical motion integrator: landing on supported lines, death at screen edges.
// Optional PLAYER_ACCEL_EN: ramping velocity (1..STEP_MAX) instead of a constant STEP.
module player_vertical_motion #(
    parameter int unsigned START_H  = 120,
    parameter int unsigned STEP     = 4,
    parameter int unsigned STEP_MAX = 8,
    parameter int unsigned LAND_DN0 = 120,
    parameter int unsigned LAND_DN1 = 240,
    parameter int unsigned LAND_UP1 = 180,
    parameter int unsigned LAND_UP2 = 300,
    parameter int unsigned KILL_BOT = 420
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    player_vertical_motion_if.slave  bus
);

    localparam int unsigned HW = 9;
    localparam int unsigned AW = 10;

    if (!(STEP > 0 && (60 % STEP) == 0 && STEP_MAX > 0 && STEP_MAX < 16)) begin : g_bad_cfg
        $error("player_vertical_motion: STEP must divide 60 and STEP_MAX must fit 4 bits");
    end

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'd0,
        ST_AIRBORNE = 2'd1,
        ST_DEAD     = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [HW-1:0]   r_height;
    logic [HW-1:0]   w_height_nx;
    logic            r_landed;
    logic            w_landed_nx;
    logic            w_sup;
    logic [AW-1:0]   w_h;
    logic [AW-1:0]   w_v;
    logic [AW-1:0]   w_cand;

    assign w_h = AW'(r_height);

    // Resting on a present line at the rest height that matches the current gravity.
    always_comb begin
        if (!bus.dir)
            w_sup = (w_h == AW'(LAND_DN0) && bus.lines[0]) ||
                    (w_h == AW'(LAND_DN1) && bus.lines[1]);
        else
            w_sup = (w_h == AW'(LAND_UP1) && bus.lines[1]) ||
                    (w_h == AW'(LAND_UP2) && bus.lines[2]);
    end

`ifdef PLAYER_ACCEL_EN
    localparam int unsigned VW = 4;

    logic [VW-1:0] r_vel;
    logic [VW-1:0] w_vel_nx;
    logic [VW-1:0] w_vel_step;
    logic          r_dir;

    // A gravity flip restarts the ramp; otherwise accelerate up to the cap.
    always_comb begin
        w_vel_step = VW'(1);
        if (bus.dir == r_dir) begin
            if (r_vel < VW'(STEP_MAX))
                w_vel_step = r_vel + VW'(1);
            else
                w_vel_step = VW'(STEP_MAX);
        end
    end

    assign w_v = AW'(w_vel_step);

    always_comb begin
        w_vel_nx = r_vel;
        if (bus.tick)
            w_vel_nx = (r_state == ST_AIRBORNE && w_state_nx == ST_AIRBORNE) ? w_vel_step : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_vel <= '0;
            r_dir <= 1'b0;
        end else if (bus.tick) begin
            r_vel <= w_vel_nx;
            r_dir <= bus.dir;
        end
    end
`else
    assign w_v = AW'(STEP);
`endif

    // Next-state: landing is checked before death so a line at the edge still catches the player.
    always_comb begin
        w_state_nx  = r_state;
        w_height_nx = r_height;
        w_landed_nx = 1'b0;
        w_cand      = '0;
        if (bus.tick) begin
            case (r_state)
                ST_GROUNDED: begin
                    if (!w_sup)
                        w_state_nx = ST_AIRBORNE;
                end
                ST_AIRBORNE: begin
                    if (!bus.dir) begin
                        w_cand = w_h + w_v;
                        if (bus.lines[0] && w_h < AW'(LAND_DN0) && AW'(LAND_DN0) <= w_cand) begin
                            w_height_nx = HW'(LAND_DN0);
                            w_state_nx  = ST_GROUNDED;
                            w_landed_nx = 1'b1;
                        end else if (bus.lines[1] && w_h < AW'(LAND_DN1) && AW'(LAND_DN1) <= w_cand) begin
                            w_height_nx = HW'(LAND_DN1);
                            w_state_nx  = ST_GROUNDED;
                            w_landed_nx = 1'b1;
                        end else if (w_cand >= AW'(KILL_BOT)) begin
                            w_height_nx = HW'(KILL_BOT);
                            w_state_nx  = ST_DEAD;
                        end else begin
                            w_height_nx = HW'(w_cand);
                        end
                    end else if (w_h > w_v) begin
                        w_cand = w_h - w_v;
                        if (bus.lines[2] && w_cand <= AW'(LAND_UP2) && AW'(LAND_UP2) < w_h) begin
                            w_height_nx = HW'(LAND_UP2);
                            w_state_nx  = ST_GROUNDED;
                            w_landed_nx = 1'b1;
                        end else if (bus.lines[1] && w_cand <= AW'(LAND_UP1) && AW'(LAND_UP1) < w_h) begin
                            w_height_nx = HW'(LAND_UP1);
                            w_state_nx  = ST_GROUNDED;
                            w_landed_nx = 1'b1;
                        end else begin
                            w_height_nx = HW'(w_cand);
                        end
                    end else begin
                        w_height_nx = '0;
                        w_state_nx  = ST_DEAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_GROUNDED;
            r_height <= HW'(START_H);
            r_landed <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_height <= w_height_nx;
            r_landed <= w_landed_nx;
        end
    end

    assign bus.height   = r_height;
    assign bus.grounded = (r_state == ST_GROUNDED);
    assign bus.landed   = r_landed;
    assign bus.is_dead  = (r_state == ST_DEAD);

endmodule

// File: tb/tb_player_vertical_motion.sv
// Bench for player_vertical_motion: vector table, corner sequences and randomized model comparison.
module tb_player_vertical_motion;

`ifdef PLAYER_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    player_vertical_motion_if bus();

    player_vertical_motion dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 grounded, 1 airborne, 2 dead
    int m_h, m_st, m_v, m_pdir;
    bit m_landed;
    int dn_pt [2] = '{120, 240};
    int dn_ln [2] = '{0, 1};
    int up_pt [2] = '{180, 300};
    int up_ln [2] = '{1, 2};

    function automatic void model_reset();
        m_h = 120; m_st = 0; m_v = 0; m_pdir = 0; m_landed = 1'b0;
    endfunction

    function automatic void model_tick(input bit d, input bit [2:0] l);
        int  best, cand, v;
        bit  sup;
        m_landed = 1'b0;
        if (m_st == 0) begin
            sup = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (!d && l[dn_ln[i]] && m_h == dn_pt[i]) sup = 1'b1;
                if (d && l[up_ln[i]] && m_h == up_pt[i]) sup = 1'b1;
            end
            if (!sup) begin m_st = 1; m_v = 0; end
        end else if (m_st == 1) begin
            if (ACCEL) v = (int'(d) != m_pdir) ? 1 : ((m_v + 1 > 8) ? 8 : m_v + 1);
            else       v = 4;
            m_v  = v;
            best = -1;
            if (!d) begin
                cand = m_h + v;
                for (int i = 0; i < 2; i++)
                    if (l[dn_ln[i]] && m_h < dn_pt[i] && dn_pt[i] <= cand && (best < 0 || dn_pt[i] < best))
                        best = dn_pt[i];
                if (best >= 0)        begin m_h = best; m_st = 0; m_landed = 1'b1; m_v = 0; end
                else if (cand >= 420) begin m_h = 420; m_st = 2; end
                else                  m_h = cand;
            end else begin
                cand = m_h - v;
                for (int i = 0; i < 2; i++)
                    if (l[up_ln[i]] && cand <= up_pt[i] && up_pt[i] < m_h && up_pt[i] > best)
                        best = up_pt[i];
                if (best >= 0)      begin m_h = best; m_st = 0; m_landed = 1'b1; m_v = 0; end
                else if (cand <= 0) begin m_h = 0; m_st = 2; end
                else                m_h = cand;
            end
        end
        m_pdir = int'(d);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic compare_all(input string nm);
        check({nm, "_height"},   int'(bus.height),   m_h);
        check({nm, "_grounded"}, int'(bus.grounded), int'(m_st == 0));
        check({nm, "_landed"},   int'(bus.landed),   int'(m_landed));
        check({nm, "_dead"},     int'(bus.is_dead),  int'(m_st == 2));
    endtask

    // One clock with the given inputs; sample 1 time unit after the edge.
    task automatic cyc(input bit t, input bit d, input bit [2:0] l);
        bus.tick = t; bus.dir = d; bus.lines = l;
        @(posedge clk);
        if (t) model_tick(d, l);
        else   m_landed = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #2;
        check("rst_height",   int'(bus.height),   120);
        check("rst_grounded", int'(bus.grounded), 1);
        check("rst_dead",     int'(bus.is_dead),  0);
        reset = 1'b1;
    endtask

    typedef struct {
        bit       dir;
        bit [2:0] lines;
        int       exp_h;
        bit       exp_g;
        bit       exp_l;
        bit       exp_d;
    } vec_t;

    vec_t vt [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int  cnt, lands, h0;
        bit       rd;
        bit [2:0] rl;

        vt[0] = '{1'b0, 3'b001, 120,                 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b0, 3'b010, 120,                 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 3'b010, ACCEL ? 121 : 124,   1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 3'b011, ACCEL ? 123 : 128,   1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 3'b000, ACCEL ? 122 : 124,   1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 3'b001, 120,                 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 3'b001, ACCEL ? 121 : 124,   1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b1, 3'b001, 120,                 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 3'b001, ACCEL ? 121 : 124,   1'b0, 1'b0, 1'b0};

        bus.tick = 1'b0; bus.dir = 1'b0; bus.lines = 3'b001;
        model_reset();
        #12;
        check("init_height",   int'(bus.height),   120);
        check("init_grounded", int'(bus.grounded), 1);
        check("init_landed",   int'(bus.landed),   0);
        check("init_dead",     int'(bus.is_dead),  0);
        reset = 1'b1;

        // Grounded on line 0 holds for 10 ticks
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b0, 3'b001);
            compare_all("t1");
            check("t1_height_const", int'(bus.height), 120);
        end

        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, vt[i].dir, vt[i].lines);
            check($sformatf("vec%0d_height", i),   int'(bus.height),   vt[i].exp_h);
            check($sformatf("vec%0d_grounded", i), int'(bus.grounded), int'(vt[i].exp_g));
            check($sformatf("vec%0d_landed", i),   int'(bus.landed),   int'(vt[i].exp_l));
            check($sformatf("vec%0d_dead", i),     int'(bus.is_dead),  int'(vt[i].exp_d));
            compare_all($sformatf("vec%0d_model", i));
        end

        // tick low: everything holds even with dir flipped
        h0 = int'(bus.height);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 3'b111);
            check("hold_height", int'(bus.height), h0);
            compare_all("hold");
        end

        // Fall from 120 onto line 1
        do_reset();
        cnt = 0; lands = 0;
        for (int k = 1; k <= 200 && cnt == 0; k++) begin
            cyc(1'b1, 1'b0, 3'b010);
            compare_all("t2");
            if (k == 1) check("t2_airborne", int'(bus.grounded), 0);
            if (bus.landed) begin lands++; cnt = k; end
        end
        check("t2_land_tick", cnt, ACCEL ? 20 : 31);
        check("t2_height", int'(bus.height), 240);
        check("t2_grounded", int'(bus.grounded), 1);
        cyc(1'b0, 1'b0, 3'b010);
        check("t2_landed_clear", int'(bus.landed), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 3'b010);
            compare_all("t2_rest");
            if (bus.landed) lands++;
        end
        check("t2_land_count", lands, 1);

        // Flip gravity up with only line 2: rise past 180 to the top edge
        cnt = 0;
        for (int k = 1; k <= 200 && cnt == 0; k++) begin
            cyc(1'b1, 1'b1, 3'b100);
            compare_all("t3");
            if (bus.is_dead) cnt = k;
        end
        check("t3_dead_tick", cnt, ACCEL ? 35 : 61);
        check("t3_height", int'(bus.height), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 3'b001);
            check("t3_frozen_height", int'(bus.height), 0);
            check("t3_frozen_dead", int'(bus.is_dead), 1);
            check("t3_frozen_grounded", int'(bus.grounded), 0);
        end

        // Free fall to the bottom boundary
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 200 && cnt == 0; k++) begin
            cyc(1'b1, 1'b0, 3'b000);
            compare_all("t4");
            if (bus.is_dead) cnt = k;
        end
        check("t4_dead_tick", cnt, ACCEL ? 42 : 76);
        check("t4_height", int'(bus.height), 420);

        // Async reset mid-flight, between clock edges
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 100 && cnt == 0; k++) begin
            cyc(1'b1, 1'b0, 3'b000);
            if (bus.height >= 9'd200) cnt = k;
        end
        check("t5_reached_200", int'(cnt != 0), 1);
        reset = 1'b0;
        model_reset();
        #1;
        check("t5_height", int'(bus.height), 120);
        check("t5_grounded", int'(bus.grounded), 1);
        check("t5_dead", int'(bus.is_dead), 0);
        #1;
        reset = 1'b1;

        // Randomized traffic against the model
        rd = 1'b0; rl = 3'b001;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) rd = ~rd;
            if ($urandom_range(0, 7) == 0)  rl = 3'($urandom);
            cyc($urandom_range(0, 3) != 0, rd, rl);
            compare_all("rnd");
            if (m_st == 2 && $urandom_range(0, 9) == 0) begin
                do_reset();
                rd = 1'b0; rl = 3'b001;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
